// File: rtl/alu_core.sv
// 32-bit registered ALU with ARM-style {N,Z,C,V} flags and fixed 1-cycle latency.
// ADD/SUB/RSB share one WIDTH+1-bit adder; subtraction is done as A + ~B + 1.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_RSB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_ORR = 3'b101;
  localparam logic [2:0] OP_EOR = 3'b110;
  localparam logic [2:0] OP_LSL = 3'b111;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             is_arith;

  // RSB swaps the operands so the minuend always lands on add_a.
  always_comb begin
    add_a   = SrcA;
    add_b   = SrcB;
    add_cin = 1'b0;
    case (ALUControl)
      OP_SUB: begin
        add_b   = ~SrcB;
        add_cin = 1'b1;
      end
      OP_RSB: begin
        add_a   = SrcB;
        add_b   = ~SrcA;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign is_arith = (ALUControl == OP_ADD) || (ALUControl == OP_SUB) || (ALUControl == OP_RSB);

  always_comb begin
    result = '0;
    case (ALUControl)
      OP_MOV:                 result = SrcB;
      OP_ADD, OP_SUB, OP_RSB: result = add_sum[WIDTH-1:0];
      OP_AND:                 result = SrcA & SrcB;
      OP_ORR:                 result = SrcA | SrcB;
      OP_EOR:                 result = SrcA ^ SrcB;
      OP_LSL:                 result = SrcA << SrcB[4:0];
      default:                result = '0;
    endcase
  end

  // Overflow on the adder inputs covers SUB/RSB too, since add_b is the inverted subtrahend.
  always_comb begin
    flag_n = result[WIDTH-1];
    flag_z = (result == '0);
    flag_c = is_arith & add_sum[WIDTH];
    flag_v = is_arith & (add_a[WIDTH-1] == add_b[WIDTH-1])
                      & (add_sum[WIDTH-1] != add_a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult <= '0;
      ALUFlags  <= 4'b0000;
    end else begin
      ALUResult <= result;
      ALUFlags  <= {flag_n, flag_z, flag_c, flag_v};
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors push hand-computed expectations,
// a monitor pops one entry per clock edge and compares result and flags.
module tb_alu_core;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  alu_core #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the result is due right after the next rising edge.
  task automatic issue(input logic rst, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp_res,
                       input logic [3:0] exp_flg, input string name);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    SrcA       = a;
    SrcB       = b;
    ALUControl = op;
    e.result = exp_res;
    e.flags  = exp_flg;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ALUResult !== e.result) begin
        errors++;
        $display("FAIL %s result: got 0x%08h expected 0x%08h", e.name, ALUResult, e.result);
      end
      checks++;
      if (ALUFlags !== e.flags) begin
        errors++;
        $display("FAIL %s flags: got %b expected %b", e.name, ALUFlags, e.flags);
      end
    end
  end

  initial begin
    int budget;
    reset      = 1'b1;
    SrcA       = 32'h0;
    SrcB       = 32'h0;
    ALUControl = 3'b000;

    //      rst   SrcA          SrcB          op      result        NZCV
    issue(1'b1, 32'h1234_5678, 32'h0000_0055, 3'b001, 32'h0000_0000, 4'b0000, "reset0");
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 32'h0000_0000, 4'b0000, "reset1");
    issue(1'b0, 32'h0000_0001, 32'h0000_0002, 3'b001, 32'h0000_0003, 4'b0000, "add_1_2");
    issue(1'b0, 32'h0000_0001, 32'h0000_0002, 3'b010, 32'hFFFF_FFFF, 4'b1000, "sub_1_2");
    issue(1'b0, 32'h0000_0001, 32'h0000_0002, 3'b100, 32'h0000_0000, 4'b0100, "and_1_2");
    issue(1'b0, 32'h0000_0001, 32'h0000_0002, 3'b000, 32'h0000_0002, 4'b0000, "mov_2");
    issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b001, 32'h8000_0000, 4'b1001, "add_ovf");
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 32'h0000_0000, 4'b0110, "add_carry");
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 3'b001, 32'h0000_0000, 4'b0111, "add_neg_ovf");
    issue(1'b0, 32'h8000_0000, 32'h0000_0001, 3'b010, 32'h7FFF_FFFF, 4'b0011, "sub_ovf");
    issue(1'b0, 32'h0000_0005, 32'h0000_0005, 3'b010, 32'h0000_0000, 4'b0110, "sub_eq");
    issue(1'b0, 32'h0000_0003, 32'h0000_000A, 3'b011, 32'h0000_0007, 4'b0010, "rsb_3_10");
    issue(1'b0, 32'h0000_0001, 32'h8000_0000, 3'b011, 32'h7FFF_FFFF, 4'b0011, "rsb_ovf");
    issue(1'b0, 32'h0000_000A, 32'h0000_0003, 3'b011, 32'hFFFF_FFF9, 4'b1000, "rsb_borrow");
    issue(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, 32'hFFF0_FFF0, 4'b1000, "orr");
    issue(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b110, 32'hFF00_FF00, 4'b1000, "eor");
    issue(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'h00F0_00F0, 4'b0000, "and_mix");
    issue(1'b0, 32'h0000_0001, 32'h0000_001F, 3'b111, 32'h8000_0000, 4'b1000, "lsl_31");
    issue(1'b0, 32'h0000_0001, 32'h0000_0020, 3'b111, 32'h0000_0001, 4'b0000, "lsl_32_wraps");
    issue(1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 3'b111, 32'hDEAD_BEEF, 4'b1000, "lsl_0");
    issue(1'b0, 32'h0000_000F, 32'hFFFF_FFE4, 3'b111, 32'h0000_00F0, 4'b0000, "lsl_4_hi_ignored");
    issue(1'b0, 32'h0000_0000, 32'h0000_0000, 3'b000, 32'h0000_0000, 4'b0100, "mov_zero");
    issue(1'b1, 32'h0000_0002, 32'h0000_0003, 3'b001, 32'h0000_0000, 4'b0000, "reset_mid");
    issue(1'b0, 32'h0000_0002, 32'h0000_0003, 3'b001, 32'h0000_0005, 4'b0000, "add_after_reset");

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
